regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the CPU register file.
- Generalises data width, depth and read-port count.
- Adds a per-register pending-write scoreboard for pipelined hazard detection.
- Adds a multi-cycle clear sequencer that zeroes the array without asserting reset.
- Sits between the decode/issue stage (reads, issue marking) and the writeback stage (writes).

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of independent read ports.
- DEBUG_REG, 20, index of the register mirrored on debug.

Ports:
- clock  in  1  rising-edge system clock.
- ctrl_reset_n  in  1  asynchronous active-low reset.
- ctrl_writeEnable  in  1  writeback write strobe.
- ctrl_writeReg  in  ADDR_WIDTH  write address.
- data_writeReg  in  DATA_WIDTH  write data.
- ctrl_readReg  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- data_readReg  out  NUM_READ*DATA_WIDTH  packed read data, same packing.
- busy_readReg  out  NUM_READ  pending bit of each read address.
- ctrl_issueEnable  in  1  mark the destination register pending.
- ctrl_issueReg  in  ADDR_WIDTH  destination being issued.
- ctrl_clear  in  1  one-cycle pulse that starts the clear sweep.
- clear_busy  out  1  high while the sweep runs.
- debug  out  DATA_WIDTH  contents of register DEBUG_REG.

Behaviour:
- Reset: ctrl_reset_n low asynchronously does all of the following.
  - Zeroes every register and every pending bit.
  - Forces the FSM to IDLE and the sweep counter to 0.
  - clear_busy=0; all data_readReg=0, busy_readReg=0 and debug=0 while reset is held.
- Register 0:
  - Reads always return 0 and busy is always 0.
  - Writes and issues to address 0 are ignored.
- Write: on posedge clock when ctrl_writeEnable=1, ctrl_writeReg!=0 and FSM=IDLE, register[ctrl_writeReg] <= data_writeReg. Data is visible on read ports from the next cycle.
- Read: combinational per port, data_readReg[k] = register[addr_k]. Same-cycle write handling is governed by REGFILE_BYPASS_EN. Outputs are never tri-stated.
- Scoreboard:
  - Issue (ctrl_issueEnable=1, reg!=0, FSM=IDLE) sets pending[ctrl_issueReg] at the clock edge.
  - A write to reg r in IDLE clears pending[r].
  - Issue and write to the same r in the same cycle leaves pending[r]=1 (the newer producer wins).
  - Issue and write to different registers in the same cycle both take effect.
  - busy_readReg[k] = pending[addr_k], combinational.
- Clear FSM:
  - States are IDLE and CLEAR.
  - IDLE -> CLEAR when ctrl_clear=1: counter <= 1, clear_busy=1 from the next cycle.
  - In CLEAR, each cycle register[counter]<=0 and pending[counter]<=0, then counter increments.
  - When counter == DEPTH-1, that register is cleared and the FSM returns to IDLE.
  - The sweep takes DEPTH-1 cycles; clear_busy falls the cycle after the last register is cleared.
  - While in CLEAR, writes, issues and further ctrl_clear pulses are dropped. Reads remain live and return whatever is currently stored.
  - ctrl_clear asserted in the same cycle as a write or issue: the write/issue is performed at that edge, then the sweep begins.
  - Reset mid-sweep aborts immediately to the reset state.
- debug = register[DEBUG_REG]; it includes the REGFILE_BYPASS_EN forwarding only when DEBUG_REG is being written.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through forwarding, FSM=IDLE):
  - A read port whose nonzero address equals ctrl_writeReg while ctrl_writeEnable=1 returns data_writeReg in the same cycle.
  - Its busy_readReg bit reads 0 unless a same-cycle issue targets that register.
- Undefined: read ports return the stored (old) value and the current pending bit. The write becomes visible the cycle after the edge.

Test Plan:
- Reset then write 0xDEADBEEF to r5 and read r5 on both ports the next cycle -> both ports return 0xDEADBEEF; busy=0.
- Write 0x12345678 to r0, then read r0 -> returns 0; an issue to r0 -> busy stays 0.
- Issue r7, then read r7 -> busy=1. Write r7 two cycles later -> busy=0 the next cycle. Issue+write r7 in the same cycle -> busy stays 1.
- Same-cycle write 0xA5A5A5A5 to r9 while reading r9 (old value 0x1):
  - REGFILE_BYPASS_EN defined -> reads 0xA5A5A5A5 that cycle.
  - Undefined -> reads 0x1, then 0xA5A5A5A5 the next cycle.
- Fill r1..r31 with nonzero values and pulse ctrl_clear:
  - clear_busy is high for exactly 31 cycles.
  - A write to r3 mid-sweep is dropped.
  - All registers read 0 afterwards; debug=0.
- Pull ctrl_reset_n low mid-sweep and mid-write with pending bits set -> immediately all data, busy, clear_busy and debug read 0; FSM=IDLE after release.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register pending-write
// scoreboard and a multi-cycle clear sequencer.
//   - Register 0 reads as zero, is never busy, and ignores writes/issues.
//   - The clear sweep zeroes registers 1..DEPTH-1, one per cycle, without reset.
//   - Optional macro REGFILE_BYPASS_EN enables same-cycle write-through
//     forwarding on the read ports (and on debug when DEBUG_REG is written).
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int DEBUG_REG  = 20
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            busy_readReg,
  input  logic                           ctrl_issueEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_issueReg,
  input  logic                           ctrl_clear,
  output logic                           clear_busy,
  output logic [DATA_WIDTH-1:0]          debug
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DBG_A = ADDR_WIDTH'(DEBUG_REG);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic idle;
  logic wr_ok;
  logic iss_ok;

  assign idle   = (state_q == ST_IDLE);
  assign wr_ok  = idle && ctrl_writeEnable && (ctrl_writeReg != '0);
  assign iss_ok = idle && ctrl_issueEnable && (ctrl_issueReg != '0);

  assign clear_busy = (state_q == ST_CLEAR);

  // Clear sequencer next state: start the sweep at register 1, stop after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = ONE;
        end
      end
      default: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  // Scoreboard next state: a write retires its register, an issue (applied last) marks it pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[ctrl_writeReg] = 1'b0;
    if (iss_ok) pend_d[ctrl_issueReg] = 1'b1;
    if (!idle) pend_d[cnt_q] = 1'b0;
    pend_d[0] = 1'b0;
  end

  // Control state: FSM, sweep counter and pending bits.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Register array: writeback in IDLE, one register zeroed per cycle while sweeping.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[ctrl_writeReg] <= data_writeReg;
    end else if (!idle) begin
      mem_q[cnt_q] <= '0;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  bz;

    assign ra = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Combinational read port; outputs held at zero for r0 and while reset is asserted.
    always_comb begin
      rd = mem_q[ra];
      bz = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (ra == ctrl_writeReg)) begin
        rd = data_writeReg;
        bz = iss_ok && (ctrl_issueReg == ra);
      end
`endif
      if ((ra == '0) || !ctrl_reset_n) begin
        rd = '0;
        bz = 1'b0;
      end
    end

    assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign busy_readReg[k] = bz;
  end

  // Debug mirror of DEBUG_REG, forwarded only when that register is being written.
  always_comb begin
    debug = mem_q[DBG_A];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (ctrl_writeReg == DBG_A)) debug = data_writeReg;
`endif
    if ((DBG_A == '0) || !ctrl_reset_n) debug = '0;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb. The driver computes the
// expected read-side response from an array-based reference model and queues
// it; a monitor on the falling edge pops and compares against the DUT.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DBG = 20;
  localparam int DEPTH = 32;

  logic           clock = 1'b0;
  logic           ctrl_reset_n = 1'b0;
  logic           ctrl_writeEnable = 1'b0;
  logic [AW-1:0]  ctrl_writeReg = '0;
  logic [DW-1:0]  data_writeReg = '0;
  logic [NR*AW-1:0] ctrl_readReg = '0;
  logic [NR*DW-1:0] data_readReg;
  logic [NR-1:0]  busy_readReg;
  logic           ctrl_issueEnable = 1'b0;
  logic [AW-1:0]  ctrl_issueReg = '0;
  logic           ctrl_clear = 1'b0;
  logic           clear_busy;
  logic [DW-1:0]  debug;

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .DEBUG_REG(DBG)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(data_readReg), .busy_readReg(busy_readReg),
    .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg),
    .ctrl_clear(ctrl_clear), .clear_busy(clear_busy), .debug(debug)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    b;
    logic             cb;
    logic [DW-1:0]    dbg;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_sweep;
  int            m_pos;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
    m_sweep = 0;
    m_pos = 0;
  endfunction

  // Expected value seen on a read of register a with the given same-cycle inputs.
  function automatic void model_read(input int a, input bit we, input int wr, input logic [DW-1:0] wd,
                                     input bit ie, input int ir,
                                     output logic [DW-1:0] d, output bit b);
    d = m_mem[a];
    b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    if (!m_sweep && we && wr != 0 && wr == a) begin
      d = wd;
      b = ie && ir == a;
    end
`endif
    if (a == 0) begin d = '0; b = 0; end
  endfunction

  task automatic step(input bit rst, input bit we, input int wr, input logic [DW-1:0] wd,
                      input bit ie, input int ir, input bit clr, input int ra0, input int ra1);
    exp_t e;
    logic [DW-1:0] d0, d1, dd;
    bit b0, b1, bd;
    ctrl_reset_n     = ~rst;
    ctrl_writeEnable = we;
    ctrl_writeReg    = AW'(wr);
    data_writeReg    = wd;
    ctrl_issueEnable = ie;
    ctrl_issueReg    = AW'(ir);
    ctrl_clear       = clr;
    ctrl_readReg     = {AW'(ra1), AW'(ra0)};
    if (rst) begin
      e = '0;
    end else begin
      model_read(ra0, we, wr, wd, ie, ir, d0, b0);
      model_read(ra1, we, wr, wd, ie, ir, d1, b1);
      model_read(DBG, we, wr, wd, ie, ir, dd, bd);
      e.d = {d1, d0};
      e.b = {b1, b0};
      e.cb = m_sweep;
      e.dbg = dd;
    end
    exp_q.push_back(e);
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else if (!m_sweep) begin
      if (we && wr != 0) begin m_mem[wr] = wd; m_pend[wr] = 0; end
      if (ie && ir != 0) m_pend[ir] = 1;
      if (clr) begin m_sweep = 1; m_pos = 1; end
    end else begin
      m_mem[m_pos] = '0;
      m_pend[m_pos] = 0;
      m_pos++;
      if (m_pos == DEPTH) m_sweep = 0;
    end
    #1;
  endtask

  task automatic rd(input int a0, input int a1);
    step(0, 0, 0, '0, 0, 0, 0, a0, a1);
  endtask

  // Monitor: compare DUT outputs with the queued expectation on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data_readReg[DW-1:0] !== e.d[DW-1:0]) begin
          errors++;
          $display("FAIL rd0_data t=%0t got %h want %h", $time, data_readReg[DW-1:0], e.d[DW-1:0]);
        end
        checks++;
        if (data_readReg[2*DW-1:DW] !== e.d[2*DW-1:DW]) begin
          errors++;
          $display("FAIL rd1_data t=%0t got %h want %h", $time, data_readReg[2*DW-1:DW], e.d[2*DW-1:DW]);
        end
        checks++;
        if (busy_readReg !== e.b) begin
          errors++;
          $display("FAIL busy t=%0t got %b want %b", $time, busy_readReg, e.b);
        end
        checks++;
        if (clear_busy !== e.cb) begin
          errors++;
          $display("FAIL clear_busy t=%0t got %b want %b", $time, clear_busy, e.cb);
        end
        checks++;
        if (debug !== e.dbg) begin
          errors++;
          $display("FAIL debug t=%0t got %h want %h", $time, debug, e.dbg);
        end
      end
    end
  end

  initial begin
    int n;
    model_reset();
    @(posedge clock);
    #1;
    // Reset state
    step(1, 0, 0, '0, 0, 0, 0, 5, 20);
    step(1, 1, 5, 32'hFFFF_FFFF, 1, 5, 0, 5, 5);
    rd(5, 20);
    // Basic write / read
    step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 5);
    rd(5, 5);
    // Register 0 is hardwired
    step(0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
    rd(0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0, 0);
    rd(0, 5);
    // Scoreboard on r7
    step(0, 0, 0, '0, 1, 7, 0, 7, 0);
    rd(7, 7);
    rd(7, 5);
    step(0, 1, 7, 32'h0000_0777, 0, 0, 0, 7, 7);
    rd(7, 7);
    step(0, 1, 7, 32'h0000_7777, 1, 7, 0, 7, 7);
    rd(7, 7);
    step(0, 1, 7, 32'h0000_1111, 1, 8, 0, 7, 8);
    rd(7, 8);
    // Same-cycle write and read on r9
    step(0, 1, 9, 32'h0000_0001, 0, 0, 0, 9, 9);
    step(0, 1, 9, 32'hA5A5_A5A5, 0, 0, 0, 9, 9);
    rd(9, 9);
    // Debug register write with forwarding
    step(0, 1, DBG, 32'hC0DE_0014, 0, 0, 0, DBG, 0);
    rd(DBG, 1);
    // Fill r1..r31, set some pending bits, then sweep
    for (int i = 1; i < DEPTH; i++)
      step(0, 1, i, 32'h1000_0000 + i * 32'h0101_0101, (i % 4) == 0, (i + 1) % DEPTH, 0, i, i - 1);
    step(0, 1, 2, 32'h2222_2222, 1, 6, 1, 2, 6);
    for (int i = 0; i < DEPTH - 1; i++)
      step(0, i == 4, 3, 32'hBAD0_0003, i == 6, 11, i == 10, 3, (i + 2) % DEPTH);
    for (int i = 0; i < DEPTH; i += 2) rd(i, i + 1);
    rd(3, DBG);
    // Reset mid-sweep and mid-write with pending bits set
    for (int i = 1; i < 8; i++) step(0, 1, i, 32'h5000_0000 | i, 1, i + 10, 0, i, i + 10);
    step(0, 0, 0, '0, 0, 0, 1, 1, 11);
    for (int i = 0; i < 5; i++) rd(10 + i, 6);
    step(1, 1, 12, 32'h7777_7777, 1, 13, 1, 12, 13);
    step(1, 1, 12, 32'h7777_7777, 0, 0, 0, 12, DBG);
    rd(12, 13);
    rd(6, 17);
    step(0, 1, 4, 32'h4444_4444, 1, 4, 0, 4, 4);
    rd(4, 4);
    // Randomised traffic
    n = 0;
    while (n < 600) begin
      bit rst_r, we_r, ie_r, clr_r;
      rst_r = ($urandom_range(0, 199) == 0);
      we_r  = ($urandom_range(0, 1) == 1);
      ie_r  = ($urandom_range(0, 2) == 0);
      clr_r = ($urandom_range(0, 79) == 0);
      step(rst_r, we_r, $urandom_range(0, DEPTH - 1), $urandom, ie_r, $urandom_range(0, DEPTH - 1),
           clr_r, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      n++;
    end
    rd(0, 0);
    // Drain the scoreboard with a bounded wait
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
